// File: rtl/reg_dump_streamer_pkg.sv
// Shared types and constants for the register dump streamer.
// State encoding, frame header and word geometry.
package dump_pkg;

  localparam int         DUMP_DATA_W    = 32;
  localparam int         BYTES_PER_WORD = DUMP_DATA_W / 8;
  localparam logic [7:0] HEADER_BYTE    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_ADDR,
    S_SEND,
    S_CSUM,
    S_DONE
  } dump_state_e;

endpackage

// File: rtl/reg_dump_streamer_if.sv
// Byte stream from the dump engine to the UART transmitter.
// Transfer happens when tx_valid and tx_ready are both high at an edge.
interface reg_dump_streamer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/reg_dump_streamer_serializer.sv
// Splits one register word into bytes, most significant first,
// with a valid/ready handshake and a last-byte flag.
module word_byte_serializer
  import dump_pkg::*;
#(
  parameter int NBYTES = BYTES_PER_WORD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                clear,
  input  logic [8*NBYTES-1:0] word,
  output logic [7:0]          data,
  output logic                valid,
  input  logic                ready,
  output logic                last
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [8*NBYTES-1:0] sh;
  logic [CW-1:0]       idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      idx   <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      idx   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      sh    <= word;
      idx   <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (last) begin
        valid <= 1'b0;
      end else begin
        sh  <= sh << 8;
        idx <= idx + CW'(1);
      end
    end
  end

  assign data = sh[8*NBYTES-1 -: 8];
  assign last = (idx == CW'(NBYTES - 1));

endmodule

// File: rtl/reg_dump_streamer.sv
// Walks the register file read port and streams a framed dump:
// header, every register MSB-first, then an XOR checksum byte.
module reg_dump_streamer
  import dump_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = DUMP_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  reg_dump_streamer_if.master tx,
  output logic                busy,
  output logic                done
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  dump_state_e state, nxt;

  logic [7:0] csum;
  logic       abort_q;
  logic       abort_pend;
  logic       xfer;
  logic       ser_load;
  logic       ser_clear;
  logic       ser_valid;
  logic       ser_last;
  logic [7:0] ser_data;

  assign xfer       = tx.tx_valid & tx.tx_ready;
  assign abort_pend = abort_q | abort;
  assign busy       = (state != S_IDLE);

  word_byte_serializer #(
    .NBYTES (NB)
  ) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load),
    .clear (ser_clear),
    .word  (rd_data),
    .data  (ser_data),
    .valid (ser_valid),
    .ready (tx.tx_ready),
    .last  (ser_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt       = state;
    ser_load  = 1'b0;
    ser_clear = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) nxt = S_HEADER;
      end
      S_HEADER: begin
        if (xfer) nxt = abort_pend ? S_IDLE : S_ADDR;
      end
      S_ADDR: begin
        nxt      = abort_pend ? S_IDLE : S_SEND;
        ser_load = !abort_pend;
      end
      S_SEND: begin
        if (xfer) begin
          if (abort_pend) begin
            nxt       = S_IDLE;
            ser_clear = 1'b1;
          end else if (ser_last) begin
            nxt = (rd_addr == LAST_ADDR) ? S_CSUM : S_ADDR;
          end
        end
      end
      S_CSUM: begin
        if (xfer) nxt = abort_pend ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        nxt  = S_IDLE;
        done = !abort_pend;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    unique case (1'b1)
      (state == S_HEADER): begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = HEADER_BYTE;
      end
      (state == S_SEND): begin
        tx.tx_valid = ser_valid;
        tx.tx_data  = ser_data;
      end
      (state == S_CSUM): begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = csum;
      end
      default: ;
    endcase
  end

  // abort is remembered until the frame actually leaves for IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      csum    <= '0;
      abort_q <= 1'b0;
    end else if (state == S_IDLE) begin
      abort_q <= 1'b0;
      if (start) begin
        rd_addr <= '0;
        csum    <= '0;
      end
    end else begin
      abort_q <= (nxt == S_IDLE) ? 1'b0 : abort_pend;
      if (state == S_SEND && xfer) begin
        csum <= csum ^ ser_data;
        if (ser_last && !abort_pend && rd_addr != LAST_ADDR)
          rd_addr <= rd_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Random register images streamed by reg_dump_streamer and compared
// with a frame model built directly from the register array.
module tb_reg_dump_streamer;

  localparam int NR    = 32;
  localparam int FRAME = 2 + NR * 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;

  logic [31:0] regs  [NR];
  logic [31:0] regs1 [NR];

  reg_dump_streamer_if tx ();

  assign rd_data = regs[rd_addr];

  reg_dump_streamer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] got_b [$];
  int         got_e [$];
  int         done_c [$];
  logic [7:0] exp_b [$];
  logic       stall = 1'b0;
  logic [7:0] sdat  = 8'h00;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // sampled mid-cycle: a transfer seen here lands on edge cyc+1
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        n_cmp++;
        if (tx.tx_valid !== 1'b1 || tx.tx_data !== sdat) begin
          n_err++;
          $display("FAIL hold: valid=%b data=%h required valid=1 data=%h",
                   tx.tx_valid, tx.tx_data, sdat);
        end
      end
      stall = tx.tx_valid && !tx.tx_ready;
      sdat  = tx.tx_data;
      if (tx.tx_valid && tx.tx_ready) begin
        got_b.push_back(tx.tx_data);
        got_e.push_back(cyc + 1);
      end
      if (done) done_c.push_back(cyc);
    end
  end

  task automatic build_exp();
    logic [7:0] x;
    logic [7:0] v;
    exp_b.delete();
    exp_b.push_back(8'hA5);
    x = 8'h00;
    for (int r = 0; r < NR; r++) begin
      for (int b = 3; b >= 0; b--) begin
        v = regs[r][8*b +: 8];
        exp_b.push_back(v);
        x = x ^ v;
      end
    end
    exp_b.push_back(x);
  endtask

  task automatic clear_logs();
    got_b.delete();
    got_e.delete();
    done_c.delete();
  endtask

  task automatic step(input logic st, input logic ab, input int rm);
    start = st;
    abort = ab;
    case (rm)
      0:       tx.tx_ready = 1'b1;
      1:       tx.tx_ready = ($urandom_range(0, 9) < 3);
      default: tx.tx_ready = 1'b0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int rm, input int budget, output int e0);
    int n;
    n = 0;
    clear_logs();
    e0 = cyc + 1;
    step(1'b1, 1'b0, rm);
    while (busy && n < budget) begin
      step(1'b0, 1'b0, rm);
      n++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    tx.tx_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (rd_addr !== 5'd0) begin
      n_err++; $display("FAIL rst_addr: got %h required 0", rd_addr);
    end
    n_cmp++;
    if (tx.tx_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_valid: got %b required 0", tx.tx_valid);
    end
    n_cmp++;
    if (tx.tx_data !== 8'h00) begin
      n_err++; $display("FAIL rst_data: got %h required 00", tx.tx_data);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rst_flags: busy=%b done=%b required 0 0", busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [7:0] lit [13];
    int e0, bad, tbad, ex;
    lit = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03,
            8'h00, 8'h01, 8'hC0, 8'h00, 8'h06, 8'h02};
    for (int r = 0; r < NR; r++) regs[r] = $urandom;
    regs[0] = 32'h0;
    regs[1] = 32'h01030001;
    regs[2] = 32'hC0000602;
    for (int r = 0; r < NR; r++) regs1[r] = regs[r];
    build_exp();
    run_frame(0, 400, e0);
    n_cmp++;
    if (got_b.size() != FRAME) begin
      n_err++; $display("FAIL f1_len: got %0d required %0d", got_b.size(), FRAME);
    end
    bad = 0;
    for (int k = 0; k < FRAME && k < got_b.size(); k++)
      if (got_b[k] !== exp_b[k]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL f1_bytes: %0d bytes differ, required 0", bad);
    end
    bad = 0;
    for (int k = 0; k < 13 && k < got_b.size(); k++)
      if (got_b[k] !== lit[k]) bad++;
    n_cmp++;
    if (bad != 0 || got_b.size() < 13) begin
      n_err++; $display("FAIL f1_prefix: %0d of 13 leading bytes differ", bad);
    end
    tbad = 0;
    for (int k = 0; k < got_e.size(); k++) begin
      if (k == 0)              ex = 1;
      else if (k == FRAME - 1) ex = 162;
      else                     ex = 3 + 5 * ((k - 1) / 4) + (k - 1) % 4;
      if (got_e[k] - e0 != ex) tbad++;
    end
    n_cmp++;
    if (tbad != 0) begin
      n_err++; $display("FAIL f1_timing: %0d transfers off-edge, required 0", tbad);
    end
    n_cmp++;
    if (done_c.size() != 1 || done_c[0] - e0 != 162) begin
      n_err++;
      $display("FAIL f1_done: pulses=%0d first=%0d required 1 at 162",
               done_c.size(), (done_c.size() > 0) ? done_c[0] - e0 : -1);
    end
    n_cmp++;
    if (busy !== 1'b0 || tx.tx_valid !== 1'b0) begin
      n_err++; $display("FAIL f1_idle: busy=%b valid=%b required 0 0", busy, tx.tx_valid);
    end
  endtask

  task automatic test_checksum();
    int e0, bad;
    for (int r = 0; r < NR; r++) regs[r] = 32'h0;
    regs[31] = 32'h01020304;
    build_exp();
    run_frame(0, 400, e0);
    n_cmp++;
    if (got_b.size() != FRAME || got_b[FRAME-1] !== 8'h04) begin
      n_err++;
      $display("FAIL csum: len=%0d last=%h required %0d and 04", got_b.size(),
               (got_b.size() > 0) ? got_b[got_b.size()-1] : 8'hxx, FRAME);
    end
    bad = 0;
    for (int k = 0; k < FRAME && k < got_b.size(); k++)
      if (got_b[k] !== exp_b[k]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL csum_bytes: %0d bytes differ, required 0", bad);
    end
  endtask

  task automatic test_backpressure();
    int e0, bad;
    for (int r = 0; r < NR; r++) regs[r] = regs1[r];
    build_exp();
    run_frame(1, 3000, e0);
    bad = 0;
    for (int k = 0; k < FRAME && k < got_b.size(); k++)
      if (got_b[k] !== exp_b[k]) bad++;
    n_cmp++;
    if (got_b.size() != FRAME || bad != 0) begin
      n_err++;
      $display("FAIL bp_bytes: len=%0d differ=%0d required %0d and 0",
               got_b.size(), bad, FRAME);
    end
    n_cmp++;
    if (done_c.size() != 1) begin
      n_err++; $display("FAIL bp_done: pulses=%0d required 1", done_c.size());
    end
  endtask

  task automatic test_back_to_back();
    int e0, bad, n, late;
    for (int r = 0; r < NR; r++) regs[r] = $urandom;
    build_exp();
    clear_logs();
    e0 = cyc + 1;
    for (int i = 0; i < 400; i++) step(1'b1, 1'b0, 0);
    n = 0;
    while (busy && n < 300) begin
      step(($urandom_range(0, 3) == 0), 1'b0, 0);
      n++;
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0);
    bad = 0;
    for (int k = 0; k < got_b.size(); k++)
      if (got_b[k] !== exp_b[k % FRAME]) bad++;
    n_cmp++;
    if (got_b.size() != 3 * FRAME || bad != 0) begin
      n_err++;
      $display("FAIL b2b_bytes: len=%0d differ=%0d required %0d and 0",
               got_b.size(), bad, 3 * FRAME);
    end
    late = 0;
    for (int i = 0; i < done_c.size(); i++)
      if (done_c[i] - e0 != 162 + 164 * i) late++;
    n_cmp++;
    if (done_c.size() != 3 || late != 0) begin
      n_err++;
      $display("FAIL b2b_done: pulses=%0d misplaced=%0d required 3 and 0",
               done_c.size(), late);
    end
    n_cmp++;
    if (got_e.size() <= FRAME || got_e[FRAME] - e0 != 165) begin
      n_err++;
      $display("FAIL b2b_restart: second header edge=%0d required 165",
               (got_e.size() > FRAME) ? got_e[FRAME] - e0 : -1);
    end
  endtask

  task automatic test_abort();
    int e0, bad;
    for (int r = 0; r < NR; r++) regs[r] = $urandom;
    build_exp();
    clear_logs();
    e0 = cyc + 1;
    step(1'b1, 1'b0, 0);
    for (int i = 1; i <= 28; i++) step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 2);
    step(1'b0, 1'b0, 2);
    step(1'b0, 1'b0, 2);
    step(1'b0, 1'b0, 0);
    bad = 0;
    for (int k = 0; k < got_b.size() && k < FRAME; k++)
      if (got_b[k] !== exp_b[k]) bad++;
    n_cmp++;
    if (got_b.size() != 23 || bad != 0) begin
      n_err++;
      $display("FAIL abort_bytes: len=%0d differ=%0d required 23 and 0",
               got_b.size(), bad);
    end
    n_cmp++;
    if (got_e.size() == 0 || got_e[got_e.size()-1] - e0 != 32) begin
      n_err++; $display("FAIL abort_edge: last transfer not at edge 32");
    end
    n_cmp++;
    if (busy !== 1'b0 || tx.tx_valid !== 1'b0) begin
      n_err++; $display("FAIL abort_idle: busy=%b valid=%b required 0 0", busy, tx.tx_valid);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0);
    n_cmp++;
    if (got_b.size() != 23 || done_c.size() != 0) begin
      n_err++;
      $display("FAIL abort_quiet: len=%0d done=%0d required 23 and 0",
               got_b.size(), done_c.size());
    end
    run_frame(0, 400, e0);
    bad = 0;
    for (int k = 0; k < FRAME && k < got_b.size(); k++)
      if (got_b[k] !== exp_b[k]) bad++;
    n_cmp++;
    if (got_b.size() != FRAME || bad != 0 || done_c.size() != 1) begin
      n_err++;
      $display("FAIL abort_next: len=%0d differ=%0d done=%0d required %0d 0 1",
               got_b.size(), bad, done_c.size(), FRAME);
    end
  endtask

  task automatic test_reset_mid();
    int e0, bad;
    for (int r = 0; r < NR; r++) regs[r] = $urandom;
    build_exp();
    clear_logs();
    step(1'b1, 1'b0, 0);
    for (int i = 1; i <= 54; i++) step(1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_addr !== 5'd0 || tx.tx_valid !== 1'b0 || tx.tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL mid_rst_out: addr=%h valid=%b data=%h required 0 0 00",
               rd_addr, tx.tx_valid, tx.tx_data);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_flags: busy=%b done=%b required 0 0", busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 400, e0);
    bad = 0;
    for (int k = 0; k < FRAME && k < got_b.size(); k++)
      if (got_b[k] !== exp_b[k]) bad++;
    n_cmp++;
    if (got_b.size() != FRAME || bad != 0) begin
      n_err++;
      $display("FAIL mid_rst_frame: len=%0d differ=%0d required %0d and 0",
               got_b.size(), bad, FRAME);
    end
    n_cmp++;
    if (got_e.size() < 2 || got_e[0] - e0 != 1 || got_e[1] - e0 != 3) begin
      n_err++; $display("FAIL mid_rst_restart: header/r0 edges not at 1 and 3");
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++) regs[r] = 32'h0;
    tx.tx_ready = 1'b1;
    test_reset();
    test_frame();
    test_checksum();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
